// File: rtl/scan_sequencer_if.sv
// Control and selection bundle between a scan controller and scan_sequencer.
// The sequencer drives the decoder select (A, valid) and status pulses.
interface scan_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             mode;
  logic [15:0]      mask;
  logic [CNT_W-1:0] dwell;
  logic [3:0]       A;
  logic             valid;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, stop, mode, mask, dwell,
    input  A, valid, busy, done, err
  );

  modport slave (
    input  start, stop, mode, mask, dwell,
    output A, valid, busy, done, err
  );
endinterface

// File: rtl/scan_sequencer.sv
// Steps a 4-bit channel index through the enabled bits of a 16-bit mask,
// holding each channel for a programmable dwell; one-shot or continuous.
module scan_sequencer #(
   parameter int CNT_W = 16
) (
   input logic            clk,
   input logic            rst_n,
   scan_sequencer_if.slave bus
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q;
   logic [15:0]      mask_q;
   logic             mode_q;
   logic [CNT_W-1:0] dwell_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       a_q;
   logic             valid_q, busy_q, done_q, err_q;

   logic [3:0]       next_idx, wrap_idx, start_idx;
   logic             has_next;
   logic [CNT_W-1:0] dwell_eff;

   assign dwell_eff = (bus.dwell == '0) ? CNT_ONE : bus.dwell;

   // Descending loop so the last hit wins: each search yields the lowest qualifying bit.
   always_comb begin
      // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
      next_idx  = '0;
      wrap_idx  = '0;
      start_idx = '0;
      has_next  = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(a_q))) begin
            next_idx = 4'(i);
            has_next = 1'b1;
         end
         if (mask_q[i])   wrap_idx  = 4'(i);
         if (bus.mask[i]) start_idx = 4'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
         state_q <= IDLE;
         mask_q  <= '0;
         mode_q  <= 1'b0;
         dwell_q <= '0;
         cnt_q   <= '0;
         a_q     <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start && !bus.stop) begin
                  if (bus.mask != '0) begin
                     mask_q  <= bus.mask;
                     mode_q  <= bus.mode;
                     dwell_q <= dwell_eff;
                     cnt_q   <= dwell_eff - CNT_ONE;
                     a_q     <= start_idx;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= SCAN;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (bus.stop) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else if (has_next) begin
                  a_q   <= next_idx;
                  cnt_q <= dwell_q - CNT_ONE;
               end else begin
                  // End of pass: wrap in continuous mode, otherwise retire to IDLE.
                  done_q <= 1'b1;
                  if (mode_q) begin
                     a_q   <= wrap_idx;
                     cnt_q <= dwell_q - CNT_ONE;
                  end else begin
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.A     = a_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer; outputs sampled on the falling edge and
// compared as a packed {A, valid, busy, done, err} vector.
module tb_scan_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   scan_sequencer_if #(.CNT_W(16)) bus ();

   scan_sequencer #(.CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] obs();
      return {bus.A, bus.valid, bus.busy, bus.done, bus.err};
   endfunction

   function automatic logic [7:0] pk(input logic [3:0] a, input logic v, input logic b,
                                     input logic d, input logic e);
      return {a, v, b, d, e};
   endfunction

   // Drives a one-cycle start pulse; returns at the falling edge of the first scan cycle.
   task automatic launch(input logic [15:0] m, input logic md, input logic [15:0] d);
      bus.mask  = m;
      bus.mode  = md;
      bus.dwell = d;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (obs() !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_held: got {A,v,b,d,e}=%h expected %h", obs(), 8'h00);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (obs() !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_release_idle: got %h expected %h", obs(), 8'h00);
      end
   endtask

   task automatic test_oneshot_full();
      logic [7:0] e;
      launch(16'hFFFF, 1'b0, 16'd2);
      for (int c = 0; c < 32; c++) begin
         e = pk(4'(c / 2), 1'b1, 1'b1, 1'b0, 1'b0);
         n_checks++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL oneshot_ffff cycle %0d: got %h expected %h", c + 1, obs(), e);
         end
         @(negedge clk);
      end
      e = pk(4'd15, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL oneshot_ffff_done: got %h expected %h", obs(), e);
      end
      @(negedge clk);
      e = pk(4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL oneshot_ffff_after: got %h expected %h", obs(), e);
      end
   endtask

   task automatic test_sparse();
      logic [3:0] seq [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
      logic [7:0] e;
      launch(16'h8421, 1'b0, 16'd3);
      for (int c = 0; c < 12; c++) begin
         e = pk(seq[c / 3], 1'b1, 1'b1, 1'b0, 1'b0);
         n_checks++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL sparse_8421 cycle %0d: got %h expected %h", c + 1, obs(), e);
         end
         @(negedge clk);
      end
      e = pk(4'd15, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL sparse_8421_done: got %h expected %h", obs(), e);
      end
      @(negedge clk);
   endtask

   task automatic test_continuous_stop();
      logic [7:0] e;
      launch(16'h0003, 1'b1, 16'd1);
      for (int c = 0; c < 6; c++) begin
         e = pk(4'(c % 2), 1'b1, 1'b1, (c >= 2) && (c % 2 == 0), 1'b0);
         n_checks++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL continuous_0003 cycle %0d: got %h expected %h", c + 1, obs(), e);
         end
         @(negedge clk);
      end
      // Current cycle shows A=0 with done; stop lands on the next edge.
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      e = pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL stop_idle cycle %0d: got %h expected %h", c, obs(), e);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_err();
      logic [7:0] e;
      launch(16'h0000, 1'b0, 16'd4);
      e = pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL err_pulse: got %h expected %h", obs(), e);
      end
      @(negedge clk);
      e = pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL err_clear: got %h expected %h", obs(), e);
      end
   endtask

   task automatic test_sampling();
      logic [7:0] e;
      launch(16'h0100, 1'b0, 16'd0);
      e = pk(4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL dwell0_first: got %h expected %h", obs(), e);
      end
      // Relaunch attempt on a new mask while the scan is still running.
      launch(16'hFFFF, 1'b1, 16'd5);
      e = pk(4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL dwell0_done: got %h expected %h", obs(), e);
      end
      @(negedge clk);
      e = pk(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL relaunch_ignored cycle %0d: got %h expected %h", c, obs(), e);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] e;
      launch(16'hFFF0, 1'b0, 16'd4);
      e = pk(4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL prereset_scan: got %h expected %h", obs(), e);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs() !== 8'h00) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected %h", obs(), 8'h00);
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++;
         if (obs() !== 8'h00) begin
            n_fail++;
            $display("FAIL post_reset_idle cycle %0d: got %h expected %h", c, obs(), 8'h00);
         end
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.mode  = 1'b0;
      bus.mask  = '0;
      bus.dwell = '0;
      test_reset();
      test_oneshot_full();
      test_sparse();
      test_continuous_stop();
      test_err();
      test_sampling();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
